// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR: one signed MAC walks all taps per accepted sample, then rescales and saturates.
// Define FIR_ROUND_EN for round-half-up before the rescale shift; truncation otherwise.
module fir_filter_mac #(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 32,
  parameter int TAPS      = 33,
  parameter int FRAC_BITS = 16,
  parameter int ACC_W     = DATA_W + COEF_W + 8,
  parameter int AW        = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_enable,
  input  logic                     i_bypass,
  input  logic                     i_clear,
  input  logic                     i_coef_wr_en,
  input  logic [AW-1:0]            i_coef_wr_addr,
  input  logic signed [COEF_W-1:0] i_coef_wr_data,
  input  logic signed [DATA_W-1:0] i_data_in,
  input  logic                     i_data_in_valid,
  output logic                     o_data_in_ready,
  output logic signed [DATA_W-1:0] o_data_out,
  output logic                     o_data_out_valid,
  output logic                     o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  localparam int PW = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`ifdef FIR_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_K = (FRAC_BITS > 0) ? (ACC_W'(1) << (FRAC_BITS-1)) : '0;
`else
  localparam logic signed [ACC_W-1:0] RND_K = '0;
`endif

  state_t                    r_state;
  logic signed [COEF_W-1:0]  r_coef [TAPS];
  logic signed [DATA_W-1:0]  r_dl   [TAPS];
  logic [AW-1:0]             r_wptr;
  logic [AW-1:0]             r_k;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_dout;
  logic                      r_vld;

  logic [AW-1:0]             w_rd_idx;
  logic signed [PW-1:0]      w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_acc_adj;
  logic signed [ACC_W-1:0]   w_shift;
  logic signed [DATA_W-1:0]  w_sat;
  logic                      w_accept;
  logic                      w_wr_ok;

  // Newest sample sits at r_wptr; tap k looks k samples back around the ring.
  always_comb begin
    if (r_wptr >= r_k) w_rd_idx = r_wptr - r_k;
    else               w_rd_idx = AW'(int'(r_wptr) + TAPS - int'(r_k));
  end

  assign w_prod     = r_coef[r_k] * r_dl[w_rd_idx];
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

  assign w_acc_adj  = r_acc + RND_K;
  assign w_shift    = w_acc_adj >>> FRAC_BITS;

  always_comb begin
    if (w_shift > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
    else if (w_shift < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
    else                        w_sat = w_shift[DATA_W-1:0];
  end

  assign w_accept = (r_state == S_IDLE) && i_enable && !i_bypass && i_data_in_valid;
  assign w_wr_ok  = (r_state == S_IDLE) && i_coef_wr_en && (int'(i_coef_wr_addr) < TAPS);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= '0;
        r_dl[i]   <= '0;
      end
    end else if (i_clear) begin
      // Coefficients and the last output survive a flush.
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_vld   <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_dl[i] <= '0;
    end else begin
      r_vld <= 1'b0;
      if (w_wr_ok) r_coef[i_coef_wr_addr] <= i_coef_wr_data;
      if (i_enable) begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_dl[r_wptr] <= i_data_in;
              r_acc        <= '0;
              r_k          <= '0;
              r_state      <= S_MAC;
            end
          end
          S_MAC: begin
            r_acc <= r_acc + w_prod_ext;
            if (r_k == AW'(TAPS-1)) begin
              r_k     <= '0;
              r_state <= S_OUT;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
          S_OUT: begin
            r_dout  <= w_sat;
            r_vld   <= 1'b1;
            r_wptr  <= (r_wptr == AW'(TAPS-1)) ? '0 : r_wptr + 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_data_in_ready  = i_bypass | ((r_state == S_IDLE) & i_enable & ~i_clear);
  assign o_data_out       = i_bypass ? i_data_in : r_dout;
  assign o_data_out_valid = i_bypass ? i_data_in_valid : r_vld;
  assign o_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_filter_mac.sv
// Scoreboard bench for fir_filter_mac: a convolution model predicts each result and its arrival cycle.
module tb_fir_filter_mac;
  localparam int DW = 32, CW = 32, TAPS = 5, FB = 16;
  localparam int AW = $clog2(TAPS);

  logic clk = 1'b0;
  logic rst_n, en, byp, clr, wen, dvld, rdy, ovld, busy;
  logic [AW-1:0] waddr;
  logic signed [CW-1:0] wdata;
  logic signed [DW-1:0] din, dout;

  fir_filter_mac #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .FRAC_BITS(FB)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_bypass(byp), .i_clear(clr),
    .i_coef_wr_en(wen), .i_coef_wr_addr(waddr), .i_coef_wr_data(wdata),
    .i_data_in(din), .i_data_in_valid(dvld), .o_data_in_ready(rdy),
    .o_data_out(dout), .o_data_out_valid(ovld), .o_busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] val; int cyc; } exp_t;
  exp_t q[$];

  logic signed [31:0] m_coef [TAPS];
  logic signed [31:0] m_hist [TAPS];   // m_hist[0] is the newest sample
  int n_tests = 0, n_fail = 0, pulses = 0, last_acc = 0;

  function automatic logic [31:0] model_out();
    logic signed [127:0] acc, a, b, t;
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      a = m_coef[k];
      b = m_hist[k];
      acc = acc + a * b;
    end
`ifdef FIR_ROUND_EN
    acc = acc + (128'sd1 <<< (FB - 1));
`endif
    t = acc >>> FB;
    if (t > 128'sd2147483647)       return 32'h7fffffff;
    else if (t < -128'sd2147483648) return 32'h80000000;
    else                            return t[31:0];
  endfunction

  function automatic void model_reset_hist();
    for (int k = 0; k < TAPS; k++) m_hist[k] = '0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !byp && ovld) begin
        pulses++;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got %h at cycle %0d, none expected", dout, cyc);
        end else begin
          e = q.pop_front();
          if (dout !== e.val || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL result: got %h at cycle %0d expected %h at cycle %0d", dout, cyc, e.val, e.cyc);
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic signed [31:0] s, input int extra, input bit track, input bit hold);
    int n = 0;
    exp_t e;
    din = s;
    dvld = 1'b1;
    @(negedge clk);
    while (!rdy && n < 100) begin @(negedge clk); n++; end
    n_tests++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL accept_timeout: ready stayed %b, required 1", rdy);
      dvld = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
    if (track) begin
      e.val = model_out();
      e.cyc = cyc + TAPS + 2 + extra;
      q.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) dvld = 1'b0;
  endtask

  task automatic coef_wr(input int a, input logic signed [31:0] d, input bit take);
    waddr = AW'(a);
    wdata = d;
    wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    if (take && a < TAPS) m_coef[a] = d;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int prev_acc;
  int pulses0;
  int v;

  initial begin
    fork monitor(); join_none
    rst_n = 1'b0; en = 1'b1; byp = 1'b0; clr = 1'b0; wen = 1'b0; dvld = 1'b0;
    din = '0; waddr = '0; wdata = '0;
    for (int k = 0; k < TAPS; k++) begin m_coef[k] = '0; m_hist[k] = '0; end
    tick(3);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_valid", 64'(ovld), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(rdy), 64'd1);
    rst_n = 1'b1;
    tick(2);

    // Impulse through ramp coefficients
    for (int k = 0; k < TAPS; k++) coef_wr(k, 32'((k + 1) << 16), 1'b1);
    send(32'sd65536, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(32'sd0, 0, 1'b1, 1'b0);
    drain();
    chk("impulse_last", 64'(dout), 64'd327680);

    // Saturation both ways
    for (int k = 0; k < TAPS; k++) coef_wr(k, 32'h7fff0000, 1'b1);
    for (int i = 0; i < 5; i++) send(32'sh7fffffff, 0, 1'b1, 1'b0);
    drain();
    chk("sat_pos", 64'(dout), 64'h000000007fffffff);
    for (int i = 0; i < 5; i++) send(32'sh80000000, 0, 1'b1, 1'b0);
    drain();
    chk("sat_neg", 64'(dout), 64'hffffffff80000000);

    // Continuous valid: one accept every TAPS+2 cycles
    for (int k = 0; k < TAPS; k++) coef_wr(k, 32'($urandom_range(0, 131072)) - 32'sd65536, 1'b1);
    for (int i = 0; i < 10; i++) begin
      prev_acc = last_acc;
      send(32'($urandom), 0, 1'b1, 1'b1);
      if (i > 0) chk("accept_spacing", 64'(last_acc - prev_acc), 64'(TAPS + 2));
    end
    dvld = 1'b0;
    drain();

    // Coefficient writes: ignored while busy or out of range, taken in idle
    send(32'sd70000, 0, 1'b1, 1'b0);
    coef_wr(0, 32'sd0, 1'b0);
    drain();
    coef_wr(7, 32'sh12345678, 1'b0);
    send(32'sd50000, 0, 1'b1, 1'b0);
    drain();
    coef_wr(0, 32'sd0, 1'b1);
    send(-32'sd90000, 0, 1'b1, 1'b0);
    drain();

    // Enable stall of three cycles mid-MAC
    send(32'sd123456, 3, 1'b1, 1'b0);
    tick(2);
    en = 1'b0;
    #1;
    chk("stall_ready", 64'(rdy), 64'd0);
    tick(3);
    en = 1'b1;
    drain();

    // Clear: mid-MAC abort, then impulse with no history
    send(32'sd77777, 0, 1'b1, 1'b0);
    send(32'sd88888, 0, 1'b1, 1'b0);
    drain();
    send(32'sd99999, 0, 1'b0, 1'b0);
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_reset_hist();
    chk("clear_busy", 64'(busy), 64'd0);
    for (int k = 0; k < TAPS; k++) coef_wr(k, 32'((k + 1) << 16), 1'b1);
    send(32'sd65536, 0, 1'b1, 1'b0);
    drain();
    chk("clear_impulse", 64'(dout), 64'd65536);

    // Rounding boundary: acc = 0x8000
    for (int k = 0; k < TAPS; k++) coef_wr(k, (k == 0) ? 32'sh8000 : 32'sd0, 1'b1);
    send(32'sd1, 0, 1'b1, 1'b0);
    drain();
`ifdef FIR_ROUND_EN
    chk("round_half", 64'(dout), 64'd1);
`else
    chk("round_half", 64'(dout), 64'd0);
`endif

    // Bypass: combinational pass-through, delay line untouched
    byp = 1'b1; din = 32'sh1234; dvld = 1'b1;
    #1;
    chk("byp_data", 64'(dout), 64'h1234);
    chk("byp_valid", 64'(ovld), 64'd1);
    chk("byp_ready", 64'(rdy), 64'd1);
    tick(1);
    chk("byp_busy", 64'(busy), 64'd0);
    byp = 1'b0; dvld = 1'b0;
    coef_wr(1, 32'sh10000, 1'b1);
    send(32'sd4242, 0, 1'b1, 1'b0);
    drain();

    // Randomized coefficients and samples with random gaps
    for (int k = 0; k < TAPS; k++) begin
      v = int'($urandom_range(0, 524288)) - 262144;
      coef_wr(k, 32'(v), 1'b1);
    end
    for (int i = 0; i < 30; i++) begin
      send(32'($urandom), 0, 1'b1, 1'b0);
      tick(int'($urandom_range(0, 3)));
    end
    drain();

    // Reset mid-MAC: outputs zero, no pulse afterwards
    send(32'sd31337, 0, 1'b0, 1'b0);
    tick(2);
    pulses0 = pulses;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dout", 64'(dout), 64'd0);
    chk("rst_mid_valid", 64'(ovld), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    tick(1);
    rst_n = 1'b1;
    for (int k = 0; k < TAPS; k++) begin m_coef[k] = '0; m_hist[k] = '0; end
    tick(TAPS + 6);
    chk("rst_no_pulse", 64'(pulses - pulses0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
